pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor that extends the team's 4-bit CLA to any width that is a multiple of 4. It builds the datapath from 4-bit lookahead groups, registers the carry between pipeline stages, and adds carry-in, subtract mode, a signed-overflow flag and a valid/ready handshake on both sides. It sits between operand-producing logic and any consumer that can apply backpressure, and sustains one result per cycle.

## Interface
- WIDTH, 16, operand and sum width in bits; must be a multiple of 4*GROUPS_PER_STAGE, otherwise elaboration fails.
- GROUPS_PER_STAGE, 1, number of 4-bit CLA groups evaluated per pipeline stage; STAGES = WIDTH/(4*GROUPS_PER_STAGE).
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand bundle on a, b, cin, sub is valid.
- in_ready  output  1  block accepts the bundle this cycle.
- a  input  WIDTH  operand A (unsigned or two's complement).
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; used only when sub=0.
- sub  input  1  1: compute a - b; 0: compute a + b + cin.
- out_valid  output  1  result on sum, cout, ovf is valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of the MSB (in subtract mode, 1 means no borrow).
- ovf  output  1  two's-complement overflow.

## Operation
- Effective operands: bx = sub ? ~b : b, c0 = sub ? 1 : cin.
- Per 4-bit group k: p = a^bx and g = a&bx, bitwise. Carries inside a group use full lookahead from the group carry-in, with no ripple inside the group. Sum bits are p ^ carry.
- Inside one stage, group carries chain from group to group. Stage s handles groups s*GROUPS_PER_STAGE to (s+1)*GROUPS_PER_STAGE-1.
- Each stage boundary registers the following:
  - the computed sum bits so far;
  - the outgoing carry;
  - the not-yet-processed slices of a and bx;
  - a per-stage valid bit.
- Final stage outputs:
  - sum is the full WIDTH bits;
  - cout is the carry out of bit WIDTH-1;
  - ovf = carry into bit WIDTH-1 XOR cout.
- Flow control:
  - The pipeline moves as a whole: advance = !out_valid || out_ready.
  - in_ready = advance.
  - A transfer happens when in_valid && in_ready.
  - On advance, every stage loads from the stage before it. Stage 0 loads the input bundle and its valid bit is set to in_valid.
  - Bubbles are not collapsed. An empty stage stays empty as it moves down the pipeline.
- Results leave in the same order the inputs were accepted. There is no loss and no duplication.
- While out_valid=1 and out_ready=0, sum, cout, ovf and out_valid hold stable.
- Width rules:
  - Arithmetic is modulo 2^WIDTH; the discarded carry appears on cout.
  - a, b, cin and sub are don't-care when in_valid=0. X on these inputs must not propagate into any valid bit.

## Timing
- Reset (rst_n=0, takes effect immediately, without waiting for a clock edge):
  - all stage valid bits are cleared, so out_valid=0;
  - sum=0, cout=0, ovf=0;
  - all pipeline data registers are cleared;
  - in_ready=1 during reset and after release, because out_valid=0.
- Reset asserted mid-operation: all in-flight results are discarded and none are emitted after release.
- Latency:
  - a bundle accepted at rising edge N appears with out_valid=1 after edge N+STAGES-1, provided no stall occurs;
  - that is STAGES cycles from the acceptance cycle to the output cycle;
  - each stall cycle adds one cycle.
- Throughput: one result per cycle while out_ready=1.
- Simultaneous events: when out_valid && out_ready && in_valid all hold in one cycle, the output is consumed and the new input is accepted on the same edge.
- in_ready is combinational from out_ready and out_valid. There is no other combinational path from input to output.
- Critical path per stage: the lookahead inside one group, plus a ripple of GROUPS_PER_STAGE group carries.

## Test plan
All scenarios use WIDTH=16, GROUPS_PER_STAGE=1 (latency 4) unless stated otherwise.
- Add, unsigned wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0, ovf=0.
- Signed overflow:
  - a=0x7FFF + b=0x0001 -> sum=0x8000, cout=0, ovf=1.
  - sub: a=0x8000 - b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - sub: a=0x0005 - b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
- Streaming with backpressure:
  - drive 8 back-to-back bundles with a=i, b=i, cin=0, sub=0, holding out_ready=0 for 3 cycles once out_valid rises;
  - required: outputs 0,2,4,...,14 in order with no loss or duplication;
  - in_ready=0 and outputs stable throughout the stall.
- Reset mid-flight:
  - assert rst_n=0 between clock edges while 3 bundles are in flight;
  - required immediately: out_valid=0, sum=0, cout=0, ovf=0;
  - after release, nothing is emitted until a new bundle is accepted, and it appears 4 cycles later.
- Random regression: 10k random a, b, cin, sub with random in_valid and out_ready, checked against a behavioural model. Repeat with WIDTH=8, GROUPS_PER_STAGE=2 (STAGES=1, latency 1) and WIDTH=32, GROUPS_PER_STAGE=2 (STAGES=4).

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Each stage folds GROUPS_PER_STAGE groups and forwards the carry and the unprocessed operand slices.
module pipelined_cla_adder #(
  parameter int WIDTH            = 16,
  parameter int GROUPS_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SW     = 4 * GROUPS_PER_STAGE;
  localparam int STAGES = WIDTH / SW;
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % SW) != 0 || WIDTH < SW) begin : g_bad_width
    $error("WIDTH must be a non-zero multiple of 4*GROUPS_PER_STAGE");
  end

  // Returns {c4, c3, c2, c1, c0}: every carry is a flat sum-of-products of the group carry-in.
  function automatic logic [4:0] cla4(input logic [3:0] p4, input logic [3:0] g4, input logic c0);
    logic [4:0] c;
    c[0] = c0;
    c[1] = g4[0] | (p4[0] & c0);
    c[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c0);
    c[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & c0);
    c[4] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0])
         | (p4[3] & p4[2] & p4[1] & p4[0] & c0);
    return c;
  endfunction

  // Handshake: the whole pipeline shifts when the output slot is empty or being consumed;
  // a bundle transfers on in_valid && in_ready, a result on out_valid && out_ready.
  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar s = 0; s < STAGES; s++) begin : stg
    localparam int REM = WIDTH - s * SW;

    logic [REM-1:0]        a_in;
    logic [REM-1:0]        bx_in;
    logic                  c_in;
    logic                  v_in;
    logic [SW-1:0]         grp_sum;
    logic [4:0]            cc [GROUPS_PER_STAGE];
    logic                  c_out;
    logic [(s+1)*SW-1:0]   sum_n;
    logic                  v_q;
    logic                  c_q;
    logic [(s+1)*SW-1:0]   sum_q;

    if (s == 0) begin : g_src
      assign a_in  = a;
      assign bx_in = sub ? ~b : b;
      assign c_in  = sub | cin;
      assign v_in  = in_valid;
      assign sum_n = grp_sum;
    end else begin : g_src
      assign a_in  = stg[s-1].g_fwd.a_q;
      assign bx_in = stg[s-1].g_fwd.bx_q;
      assign c_in  = stg[s-1].c_q;
      assign v_in  = stg[s-1].v_q;
      assign sum_n = {grp_sum, stg[s-1].sum_q};
    end

    always_comb begin
      logic [3:0] p;
      logic [3:0] g;
      logic       carry;
      carry   = c_in;
      grp_sum = '0;
      for (int k = 0; k < GROUPS_PER_STAGE; k++) begin
        p     = a_in[k*4 +: 4] ^ bx_in[k*4 +: 4];
        g     = a_in[k*4 +: 4] & bx_in[k*4 +: 4];
        cc[k] = cla4(p, g, carry);
        grp_sum[k*4 +: 4] = p ^ cc[k][3:0];
        carry = cc[k][4];
      end
      c_out = carry;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        c_q   <= c_out;
        sum_q <= sum_n;
      end
    end

    if (s < LAST) begin : g_fwd
      logic [REM-SW-1:0] a_q;
      logic [REM-SW-1:0] bx_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bx_q <= '0;
        end else if (advance) begin
          a_q  <= a_in[REM-1:SW];
          bx_q <= bx_in[REM-1:SW];
        end
      end
    end else begin : g_ovf
      // Signed overflow: carry into the MSB differs from carry out of it.
      logic ovf_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= cc[GROUPS_PER_STAGE-1][3] ^ c_out;
        end
      end
    end
  end

  assign out_valid = stg[LAST].v_q;
  assign sum       = stg[LAST].sum_q;
  assign cout      = stg[LAST].c_q;
  assign ovf       = stg[LAST].g_ovf.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder (WIDTH=16, one group per stage): directed vectors, backpressure,
// mid-flight reset and a random stream, all scored through an expected-result queue.
module tb_pipelined_cla_adder;

  localparam int W      = 16;
  localparam int GPS    = 1;
  localparam int STAGES = W / (4 * GPS);
  localparam int RW     = W + 2;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  pipelined_cla_adder #(.WIDTH(W), .GROUPS_PER_STAGE(GPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // Reference result packed as {sum, cout, ovf}.
  function automatic logic [RW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic c, input logic s);
    logic [W-1:0] yb;
    logic         c0;
    logic [W:0]   full;
    logic         v;
    yb   = s ? ~y : y;
    c0   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yb} + {{W{1'b0}}, c0};
    v    = (x[W-1] == yb[W-1]) && (full[W-1] != x[W-1]);
    return {full[W-1:0], full[W], v};
  endfunction

  // scoreboard / output monitor
  logic          stalled = 1'b0;
  logic [RW-1:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      check("in_ready", in_ready, !out_valid || out_ready);
      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", {sum, cout, ovf}, held);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("result", {sum, cout, ovf}, exp_q.pop_front());
      end
      stalled = out_valid && !out_ready;
      held    = {sum, cout, ovf};
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the accepting edge
  task automatic drive_slot();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input logic s, input logic [RW-1:0] e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1; a = x; b = y; cin = c; sub = s;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      drive_slot();
    end
    if (acc) exp_q.push_back(e);
    else check("send_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_m(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    send(x, y, c, s, model(x, y, c, s));
  endtask

  task automatic drain();
    for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain", exp_q.size(), 0);
    drive_slot();
  endtask

  logic          rand_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [RW-1:0] snap;
    int            lat;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {sum, cout, ovf}, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    drive_slot();

    // directed vectors with hand-derived results
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0});
    send(16'h1234, 16'h4321, 1'b1, 1'b0, {16'h5556, 1'b0, 1'b0});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    send(16'h0005, 16'h0007, 1'b1, 1'b1, {16'hFFFE, 1'b0, 1'b0});
    drain();

    // streaming with a 3-cycle stall on the first result
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(W'(i), W'(i), 1'b0, 1'b0, {W'(2 * i), 1'b0, 1'b0});
      end
      begin
        for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
        check("stall_seen_valid", out_valid, 1);
        snap = {sum, cout, ovf};
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          check("stall_in_ready", in_ready, 0);
          check("stall_data", {sum, cout, ovf}, snap);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset while three bundles are in flight
    send_m(16'h1111, 16'h2222, 1'b0, 1'b0);
    send_m(16'h3333, 16'h4444, 1'b1, 1'b0);
    send_m(16'h5555, 16'h0101, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_outputs", {sum, cout, ovf}, 0);
    check("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_quiet", out_valid, 0);
    end
    drive_slot();
    send(16'h00F0, 16'h0F0F, 1'b1, 1'b0, {16'h1000, 1'b0, 1'b0});
    lat = 0;
    for (int i = 0; i < 50 && !out_valid; i++) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, STAGES);
    drain();

    // random regression with random gaps and random backpressure
    rand_ready = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap == 3) drive_slot();
      send_m(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rand_ready = 1'b0;
    out_ready  = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
